// File: rtl/multicycle_divider.sv
// Iterative signed restoring divider: one shift-and-subtract step per clock,
// start strobe in, single-cycle ready pulse out. Truncating quotient.
module multicycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, divisorMag;
  logic             signA, signB, divZero, ovf;

  logic [WIDTH:0]   magAExt, magBExt, shifted, trial;
  logic             zeroIn, ovfIn, finish;

  // Magnitudes are formed one bit wider so negating the most negative value
  // is exact; the low WIDTH bits then hold it as an unsigned number.
  assign magAExt = data_operandA[WIDTH-1] ? -{1'b1, data_operandA} : {1'b0, data_operandA};
  assign magBExt = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};
  assign zeroIn  = (data_operandB == '0);
  assign ovfIn   = (data_operandA == MIN_NEG) && (data_operandB == '1);
  assign finish  = (state == BUSY) && (count == LAST);

  // Partial remainder stays below |B|, so one extra bit covers the trial sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisorMag};

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (ctrl_DIV)    stateNext = BUSY;
    else if (finish) stateNext = DONE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count          <= '0;
      quo            <= '0;
      rem            <= '0;
      divisorMag     <= '0;
      signA          <= 1'b0;
      signB          <= 1'b0;
      divZero        <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (finish) begin
        data_resultRDY <= 1'b1;
        if (divZero) begin
          data_result    <= '0;
          data_remainder <= rem;
          data_exception <= 1'b1;
        end else if (ovf) begin
          data_result    <= MIN_NEG;
          data_remainder <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= (signA ^ signB) ? -quo : quo;
          data_remainder <= signA ? -rem : rem;
          data_exception <= 1'b0;
        end
      end
      if (ctrl_DIV) begin
        // Special operands skip the iterations and finish on the next edge;
        // a divide-by-zero parks the raw dividend in rem for the output.
        signA      <= data_operandA[WIDTH-1];
        signB      <= data_operandB[WIDTH-1];
        divZero    <= zeroIn;
        ovf        <= ovfIn;
        quo        <= magAExt[WIDTH-1:0];
        divisorMag <= magBExt[WIDTH-1:0];
        rem        <= zeroIn ? data_operandA : '0;
        count      <= (zeroIn || ovfIn) ? LAST : '0;
      end else if (state == BUSY && !finish) begin
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        count <= count + 1'b1;
      end
    end
  end

endmodule
